// File: rtl/controlador_de_acesso_pkg.sv
// Shared definitions for the access controller: FSM states, comparator
// verdict codes, null user code and grant counter width.
package controlador_de_acesso_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        LIVRE  = 2'd0,
        EM_USO = 2'd1,
        TROCA  = 2'd2,
        ERRO   = 2'd3
    } estado_t;

    // Comparator verdicts on S.
    localparam logic [1:0] NENHUM   = 2'b00;
    localparam logic [1:0] INTERF1  = 2'b01;
    localparam logic [1:0] INTERF0  = 2'b10;
    localparam logic [1:0] INVALIDO = 2'b11;

    // "No user" code.
    localparam logic [2:0] CODIGO_NULO = 3'b000;

    // Width of the grant down-counter.
    localparam int LARGURA_CONT = 8;

    // One-hot grant for an interface index (0 -> 01, 1 -> 10).
    function automatic logic [1:0] concede_de(input logic interf);
        return interf ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/controlador_de_acesso_contador.sv
// Grant-length down-counter: load, decrement (saturating at zero), zero flag.
module contador_uso
    import controlador_de_acesso_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_carregar,
    input  logic [LARGURA_CONT-1:0] i_valor,
    input  logic                    i_decrementar,
    output logic [LARGURA_CONT-1:0] o_contagem,
    output logic                    o_zero
);

    logic [LARGURA_CONT-1:0] r_contagem;

    // Load has priority over decrement; never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_contagem <= '0;
        end else if (i_carregar) begin
            r_contagem <= i_valor;
        end else if (i_decrementar && (r_contagem != '0)) begin
            r_contagem <= r_contagem - 1'b1;
        end
    end

    assign o_contagem = r_contagem;
    assign o_zero     = (r_contagem == '0);

endmodule

// File: rtl/controlador_de_acesso.sv
// Access controller: grants a shared resource to one of two interfaces
// based on the external comparator verdict, keeps a one-entry wait slot
// for the loser, and hands over after a dead cycle when the grant ends.
// All outputs are registered.
//
// There is no valid/ready handshake here: S is a level verdict, sampled
// only while the resource is free (LIVRE); liberar is a level sampled only
// while a grant is active (EM_USO). Any other input is ignored.
module controlador_de_acesso
    import controlador_de_acesso_pkg::*;
#(
    parameter int TEMPO_USO = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] User0,
    input  logic [2:0] User1,
    input  logic [1:0] S,
    input  logic [2:0] UserMenorPrioridade,
    input  logic       liberar,
    output logic [1:0] concede,
    output logic [2:0] usuarioAtivo,
    output logic [2:0] usuarioEspera,
    output logic       esperaValida,
    output logic       erro,
    output estado_t    o_estado
);

    // Counter is loaded with TEMPO_USO-1 so the grant lasts TEMPO_USO cycles.
    localparam logic [LARGURA_CONT-1:0] CARGA = LARGURA_CONT'(TEMPO_USO - 1);

    estado_t    r_estado;
    logic [1:0] r_concede;
    logic [2:0] r_usuario_ativo;
    logic [2:0] r_usuario_espera;
    logic       r_espera_valida;
    logic       r_interf_espera;
    logic       r_erro;

    estado_t    w_estado_prox;
    logic [1:0] w_concede_prox;
    logic [2:0] w_usuario_ativo_prox;
    logic [2:0] w_usuario_espera_prox;
    logic       w_espera_valida_prox;
    logic       w_interf_espera_prox;
    logic       w_erro_prox;
    logic       w_carregar;
    logic       w_decrementar;
    logic       w_zero;
    logic [LARGURA_CONT-1:0] w_contagem;

    contador_uso u_contador (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_carregar    (w_carregar),
        .i_valor       (CARGA),
        .i_decrementar (w_decrementar),
        .o_contagem    (w_contagem),
        .o_zero        (w_zero)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado         <= LIVRE;
            r_concede        <= 2'b00;
            r_usuario_ativo  <= CODIGO_NULO;
            r_usuario_espera <= CODIGO_NULO;
            r_espera_valida  <= 1'b0;
            r_interf_espera  <= 1'b0;
            r_erro           <= 1'b0;
        end else begin
            r_estado         <= w_estado_prox;
            r_concede        <= w_concede_prox;
            r_usuario_ativo  <= w_usuario_ativo_prox;
            r_usuario_espera <= w_usuario_espera_prox;
            r_espera_valida  <= w_espera_valida_prox;
            r_interf_espera  <= w_interf_espera_prox;
            r_erro           <= w_erro_prox;
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        w_estado_prox         = r_estado;
        w_concede_prox        = r_concede;
        w_usuario_ativo_prox  = r_usuario_ativo;
        w_usuario_espera_prox = r_usuario_espera;
        w_espera_valida_prox  = r_espera_valida;
        w_interf_espera_prox  = r_interf_espera;
        w_erro_prox           = 1'b0;
        w_carregar            = 1'b0;
        w_decrementar         = 1'b0;

        case (r_estado)
            LIVRE: begin
                case (S)
                    INTERF0, INTERF1: begin
                        w_estado_prox        = EM_USO;
                        w_carregar           = 1'b1;
                        w_concede_prox       = concede_de(S == INTERF1);
                        w_usuario_ativo_prox = (S == INTERF1) ? User1 : User0;
                        // The loser (the other interface) waits, if there is one.
                        if (UserMenorPrioridade != CODIGO_NULO) begin
                            w_usuario_espera_prox = UserMenorPrioridade;
                            w_espera_valida_prox  = 1'b1;
                            w_interf_espera_prox  = (S == INTERF0);
                        end
                    end
                    INVALIDO: begin
                        w_estado_prox = ERRO;
                        w_erro_prox   = 1'b1;
                    end
                    default: ;
                endcase
            end

            EM_USO: begin
                w_decrementar = 1'b1;
                // Counter at zero and liberar together still give one exit.
                if (w_zero || liberar) begin
                    w_concede_prox       = 2'b00;
                    w_usuario_ativo_prox = CODIGO_NULO;
                    w_estado_prox        = r_espera_valida ? TROCA : LIVRE;
                end
            end

            TROCA: begin
                w_estado_prox         = EM_USO;
                w_carregar            = 1'b1;
                w_concede_prox        = concede_de(r_interf_espera);
                w_usuario_ativo_prox  = r_usuario_espera;
                w_usuario_espera_prox = CODIGO_NULO;
                w_espera_valida_prox  = 1'b0;
            end

            ERRO: begin
                w_estado_prox = LIVRE;
            end

            default: begin
                w_estado_prox = LIVRE;
            end
        endcase
    end

    assign concede       = r_concede;
    assign usuarioAtivo  = r_usuario_ativo;
    assign usuarioEspera = r_usuario_espera;
    assign esperaValida  = r_espera_valida;
    assign erro          = r_erro;
    assign o_estado      = r_estado;

endmodule

// File: doc/controlador_de_acesso.md
CONTROLADOR_DE_ACESSO -- requirements
Module: controlador_de_acesso

Interface
REQ-001 Parameter TEMPO_USO, default 8: grant duration in clock cycles, legal range 2..255.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 User0  input  3  code of the user at interface 0; 000 = no request.
REQ-005 User1  input  3  code of the user at interface 1; 000 = no request.
REQ-006 S  input  2  comparator verdict: 00 none, 10 interface 0 wins, 01 interface 1 wins, 11 invalid.
REQ-007 UserMenorPrioridade  input  3  loser's code from the comparator; 000 if no loser.
REQ-008 liberar  input  1  active user releases the resource early; sampled only in EM_USO.
REQ-009 concede  output  2  one-hot grant: bit 0 = interface 0, bit 1 = interface 1; 00 = resource free.
REQ-010 usuarioAtivo  output  3  code of the granted user; 000 when free.
REQ-011 usuarioEspera  output  3  code held in the one-entry wait slot; 000 when empty.
REQ-012 esperaValida  output  1  wait slot occupied.
REQ-013 erro  output  1  one-cycle pulse on an invalid verdict.

Function
REQ-014 FSM states: LIVRE, EM_USO, TROCA, ERRO; encoding is free.
REQ-015 LIVRE, S=10: next cycle EM_USO, concede=01, usuarioAtivo=User0.
REQ-016 LIVRE, S=01: next cycle EM_USO, concede=10, usuarioAtivo=User1.
REQ-017 LIVRE, on the transition of REQ-015/016 with UserMenorPrioridade nonzero: latch the code, the losing interface index, and esperaValida=1.
REQ-018 LIVRE, S=00: remain in LIVRE; all outputs hold.
REQ-019 LIVRE, S=11: enter ERRO for exactly one cycle with erro=1; concede stays 00; then return to LIVRE.
REQ-020 Grant timing: grant is registered; concede asserts on the cycle after the qualifying S is sampled.
REQ-021 EM_USO, down-counter: loaded with TEMPO_USO-1 on entry and decremented every cycle.
REQ-022 EM_USO, grant length: concede stays high for exactly TEMPO_USO cycles unless liberar ends it early.
REQ-023 EM_USO exit: leave when the counter reaches 0, or on the cycle after liberar=1, whichever comes first.
REQ-024 EM_USO inputs ignored: S, User0 and User1 are not acted on, so no preemption.
REQ-025 EM_USO wait slot: not overwritten.
REQ-026 EM_USO exit target: go to TROCA if esperaValida=1, else go to LIVRE.
REQ-027 TROCA: lasts one cycle with concede=00, a dead cycle between owners.
REQ-028 TROCA, next cycle: EM_USO granted to the stored interface, usuarioAtivo=usuarioEspera, slot cleared, counter reloaded.
REQ-029 Release outputs: on entering LIVRE, concede=00 and usuarioAtivo=000.
REQ-030 liberar and counter=0 in the same cycle: a single exit occurs.
REQ-031 liberar outside EM_USO: ignored.
REQ-032 concede never has both bits set; erro and concede are never both nonzero.

Reset
REQ-033 On rst_n=0, immediately set state LIVRE, counter 0, concede=00, usuarioAtivo=000, usuarioEspera=000, esperaValida=0, erro=0.
REQ-034 Reset asserted mid-grant or during TROCA drops the grant immediately and empties the wait slot.
REQ-035 After release of rst_n, the first S sample occurs on the next rising edge.

Structure
REQ-036 Shared package holds: the state encoding, the S verdict constants (NENHUM=00, INTERF1=01, INTERF0=10, INVALIDO=11), and the null code 000.
REQ-037 The comparator is instantiated by the parent, not inside this block.
REQ-038 The grant counter is a natural sub-module: contador_uso, with load, decrement and zero flag, width 8.

Verification
REQ-039 Reset, then User0=110, User1=011, S=10, UPM=011: concede=01 for 8 cycles, usuarioEspera=011, esperaValida=1; 1 dead cycle; concede=10 for 8 cycles, usuarioAtivo=011; then LIVRE with all outputs zero.
REQ-040 S=01, UPM=000, liberar pulsed in the 3rd grant cycle: concede=10 for 3 cycles, then 00; no TROCA; esperaValida stays 0.
REQ-041 S=11 in LIVRE: erro=1 for one cycle, concede=00 throughout, return to LIVRE.
REQ-042 S changes to 01 during interface-0 grant: no change to concede or to the wait slot.
REQ-043 rst_n low in the 4th grant cycle with the wait slot full: all outputs zero in the same cycle; no grant after rst_n rises until a new S sample.
REQ-044 liberar=1 coincident with counter=0: exactly one TROCA cycle, and the second grant is full length.
